// File: rtl/packed_sat_alu.sv
// Packed signed-lane ALU: saturating add/sub and wrapping add in one cycle,
// or a lane-serial horizontal sum of A, with results held behind valid/ready.
module packed_sat_alu #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    parameter int W      = LANE_W * LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out,
    output logic [LANES-1:0] sat
);

    localparam logic [1:0] OP_ADDS = 2'b00;
    localparam logic [1:0] OP_SUBS = 2'b01;
    localparam logic [1:0] OP_PADD = 2'b10;
    localparam logic [1:0] OP_RED  = 2'b11;

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES - 1);

    localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RED  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      out_q, out_d;
    logic [LANES-1:0]  sat_q, sat_d;
    logic [W-1:0]      red_a_q, red_a_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [W-1:0]      ew_res;
    logic [LANES-1:0]  ew_sat;
    logic              accept;
    logic [LANE_W-1:0] lane_cur;
    logic [W-1:0]      lane_ext;
    logic [W-1:0]      red_sum;

    // Each lane is computed one bit wider so the true sign is available for
    // overflow detection; nothing propagates into the neighbouring lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LANE_W-1:0] a_l;
        logic [LANE_W-1:0] b_l;
        logic [LANE_W-1:0] res_l;
        logic [LANE_W:0]   sum_x;
        logic [LANE_W:0]   diff_x;
        logic [LANE_W:0]   pick_x;
        logic              ovf;

        assign a_l    = A[gi*LANE_W +: LANE_W];
        assign b_l    = B[gi*LANE_W +: LANE_W];
        assign sum_x  = {a_l[LANE_W-1], a_l} + {b_l[LANE_W-1], b_l};
        assign diff_x = {a_l[LANE_W-1], a_l} - {b_l[LANE_W-1], b_l};

        always_comb begin
            pick_x = (op == OP_SUBS) ? diff_x : sum_x;
            ovf    = pick_x[LANE_W] ^ pick_x[LANE_W-1];
            res_l  = pick_x[LANE_W-1:0];
            if (ovf && (op != OP_PADD)) begin
                res_l = pick_x[LANE_W] ? LANE_MIN : LANE_MAX;
            end
        end

        assign ew_res[gi*LANE_W +: LANE_W] = res_l;
        assign ew_sat[gi]                  = ovf;
    end

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    assign out_valid = (state_q == S_HOLD);
    assign out       = out_q;
    assign sat       = sat_q;
    assign accept    = in_valid && in_ready;

    // The latched operand shifts down one lane per cycle, so the lane being
    // summed is always the bottom one.
    assign lane_cur = red_a_q[LANE_W-1:0];
    assign lane_ext = {{(W-LANE_W){lane_cur[LANE_W-1]}}, lane_cur};
    assign red_sum  = acc_q + lane_ext;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sat_d   = sat_q;
        red_a_d = red_a_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept) begin
                    if (op == OP_RED) begin
                        red_a_d = A;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_RED;
                    end else begin
                        out_d   = ew_res;
                        sat_d   = ew_sat;
                        state_d = S_HOLD;
                    end
                end else if ((state_q == S_HOLD) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_RED: begin
                acc_d   = red_sum;
                red_a_d = red_a_q >> LANE_W;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    out_d   = red_sum;
                    sat_d   = '0;
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            sat_q   <= '0;
            red_a_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
            red_a_q <= red_a_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_packed_sat_alu.sv
// Scoreboard bench for packed_sat_alu: stimulus queues expected results and
// their due cycle, a negedge monitor pops and compares on each transfer.
module tb_packed_sat_alu;

    localparam int LANE_W = 4;
    localparam int LANES  = 4;
    localparam int W      = LANE_W * LANES;

    typedef struct {
        logic [W-1:0]     res;
        logic [LANES-1:0] s;
        int               due;
        string            name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       op_i = 2'b00;
    logic [W-1:0]     a_i = '0;
    logic [W-1:0]     b_i = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     dut_out;
    logic [LANES-1:0] dut_sat;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   first_seen = 0;
    bit   pend = 1'b0;

    packed_sat_alu #(.LANE_W(LANE_W), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .A         (a_i),
        .B         (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dut_out),
        .sat       (dut_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // One line per completed transfer; latency is checked against the cycle
    // the held result first appeared.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pend = 1'b0;
        end else if (out_valid) begin
            if (!pend) first_seen = cyc;
            if (out_ready) begin
                chk(exp_q.size() != 0, "unexpected_result", {12'h0, dut_sat, dut_out}, 32'h0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    $display("result %-12s out=0x%04h sat=%04b cycle=%0d", e.name, dut_out, dut_sat, first_seen);
                    chk({dut_sat, dut_out} == {e.s, e.res}, e.name, {12'h0, dut_sat, dut_out}, {12'h0, e.s, e.res});
                    chk(first_seen == e.due, {e.name, "_latency"}, first_seen, e.due);
                end
                pend = 1'b0;
            end else begin
                pend = 1'b1;
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic [LANES-1:0] s, input int lat, input string nm);
        exp_t e;
        op_i = o; a_i = a; b_i = b; in_valid = 1'b1;
        e.res = r; e.s = s; e.due = cyc + lat; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_red(input logic [W-1:0] a, input logic [W-1:0] r, input string nm);
        issue(2'b11, a, '0, r, '0, 1 + LANES, nm);
        for (int k = 0; k < LANES; k++) begin
            if (k % 2 == 1) begin
                in_valid = 1'b1; op_i = 2'b00; a_i = 16'h1111; b_i = 16'h1111;
            end
            @(negedge clk);
            chk(in_ready == 1'b0, "red_in_ready", {31'h0, in_ready}, 32'h0);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk(out_valid == 1'b0, "reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk(in_ready == 1'b1, "reset_in_ready", {31'h0, in_ready}, 32'h1);
        chk(dut_out == '0, "reset_out", {16'h0, dut_out}, 32'h0);
        chk(dut_sat == '0, "reset_sat", {28'h0, dut_sat}, 32'h0);

        issue(2'b00, 16'h7777, 16'h7777, 16'h7777, 4'b1111, 1, "adds_pos");
        issue(2'b00, 16'h8888, 16'h8888, 16'h8888, 4'b1111, 1, "adds_neg");
        issue(2'b00, 16'h4444, 16'hDDDD, 16'h1111, 4'b0000, 1, "adds_mix");
        issue(2'b01, 16'h7777, 16'h8888, 16'h7777, 4'b1111, 1, "subs_pos");
        issue(2'b01, 16'h1234, 16'h1111, 16'h0123, 4'b0000, 1, "subs_plain");
        issue(2'b10, 16'h7777, 16'h1111, 16'h8888, 4'b1111, 1, "padd_wrap");
        issue(2'b10, 16'h8888, 16'h8888, 16'h0000, 4'b1111, 1, "padd_neg");
        idle(2);

        run_red(16'h1234, 16'h000A, "red_1234");
        run_red(16'h8888, 16'hFFE0, "red_8888");
        run_red(16'hFFFF, 16'hFFFC, "red_ffff");
        idle(2);

        out_ready = 1'b0;
        issue(2'b01, 16'h8000, 16'h1000, 16'h8000, 4'b1000, 1, "bp_hold");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(out_valid == 1'b1, "bp_out_valid", {31'h0, out_valid}, 32'h1);
            chk(dut_out == 16'h8000, "bp_out_stable", {16'h0, dut_out}, 32'h8000);
            chk(dut_sat == 4'b1000, "bp_sat_stable", {28'h0, dut_sat}, 32'h8);
            chk(in_ready == 1'b0, "bp_in_ready", {31'h0, in_ready}, 32'h0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue(2'b00, 16'h1111, 16'h2222, 16'h3333, 4'b0000, 1, "bp_release");
        idle(2);

        issue(2'b00, 16'h0123, 16'h1111, 16'h1234, 4'b0000, 1, "stream0");
        issue(2'b00, 16'h7000, 16'h1234, 16'h7234, 4'b1000, 1, "stream1");
        issue(2'b00, 16'h8F00, 16'hF1FF, 16'h80FF, 4'b1000, 1, "stream2");
        issue(2'b00, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 1, "stream3");
        issue(2'b00, 16'h3456, 16'h4321, 16'h7777, 4'b0000, 1, "stream4");
        issue(2'b00, 16'h3456, 16'h4444, 16'h7777, 4'b0111, 1, "stream5");
        issue(2'b00, 16'hC9A7, 16'hC8B1, 16'h8887, 4'b0111, 1, "stream6");
        issue(2'b00, 16'h5AF1, 16'h2E2F, 16'h7810, 4'b0000, 1, "stream7");
        idle(2);

        // Reduction aborted by reset in its second cycle; nothing is queued.
        op_i = 2'b11; a_i = 16'h7777; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk(out_valid == 1'b0, "midred_out_valid", {31'h0, out_valid}, 32'h0);
        chk(in_ready == 1'b1, "midred_in_ready", {31'h0, in_ready}, 32'h1);
        chk(dut_out == '0, "midred_out", {16'h0, dut_out}, 32'h0);
        chk(dut_sat == '0, "midred_sat", {28'h0, dut_sat}, 32'h0);
        run_red(16'h1111, 16'h0004, "red_after_rst");

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "drain", exp_q.size(), 32'h0);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/packed_sat_alu.md
# packed_sat_alu

Parametrised packed-lane arithmetic unit: the successor to the fixed 4×4-bit PADDSB path in the datapath ALU. It splits a LANES×LANE_W-bit word into signed lanes and performs saturating add, saturating subtract, wrapping add, or a multi-cycle horizontal reduction. Results are registered behind a valid/ready handshake so the execute stage can stall on it. Per-lane saturation flags are reported with each result.

## Interface
- LANE_W, 4, bits per signed lane (≥2)
- LANES, 4, lane count (≥2); W = LANE_W*LANES
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- op  in  2  00 PADDSB, 01 PSUBSB, 10 PADD (wrap), 11 RED (sum of A's lanes)
- A  in  W  operand A, lane i = A[i*LANE_W +: LANE_W]
- B  in  W  operand B (ignored for RED)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out  out  W  result
- sat  out  LANES  per-lane saturation flag for the held result

## Operation
- States: IDLE, RED, HOLD. Reset → IDLE, out=0, sat=0, out_valid=0, in_ready=1.
- Accept = in_valid && in_ready. in_ready = (IDLE) || (HOLD && out_ready); 0 in RED.
- Accept with op≠RED: compute all lanes combinationally, register into out/sat, → HOLD.
  - PADDSB: lane = A_i + B_i, clamp to [−2^(LANE_W−1), 2^(LANE_W−1)−1]; sat_i=1 if clamped.
  - PSUBSB: lane = A_i − B_i, same clamp; sat_i=1 if clamped.
  - PADD: lane = (A_i + B_i) mod 2^LANE_W; sat_i = signed overflow occurred (result not clamped).
  - Overflow detect: operands same sign (add) / opposite sign (sub) and result sign differs; positive overflow → max, negative → min.
  - No carry crosses lane boundaries.
- Accept with op=RED: latch A, acc=0, lane counter=0, → RED. Each RED cycle: acc += sign-extended lane[cnt], cnt++. After lane LANES−1 is added, out=acc (W-bit, sign-extended two's complement; cannot overflow since LANES≥2), sat=0, → HOLD.
- HOLD: out_valid=1; out/sat held stable until out_ready. out_ready && !in_valid → IDLE, out_valid=0 next cycle (out/sat retain last value). out_ready && in_valid → new request accepted same edge (back-to-back).
- in_valid while in_ready=0: ignored, not queued; requester must hold.
- op, A, B sampled only on the accept edge; changes afterwards have no effect.
- rst in any state (including mid-RED): → IDLE next edge, partial reduction discarded, all outputs to reset values.

## Timing
- Elementwise ops: accept at edge N → out_valid=1 after edge N (1-cycle latency); throughput 1/cycle with out_ready held high.
- RED: accept at edge N → RED for LANES cycles → out_valid=1 after edge N+LANES; in_ready=0 throughout RED.
- out_valid deasserts after the edge where out_ready=1 unless a new elementwise op is accepted on that edge (then stays 1 with new data).
- rst dominates all other inputs on the same edge.

## Test plan (LANE_W=4, LANES=4)
- PADDSB 0x7777+0x7777 → out=0x7777, sat=1111; 0x8888+0x8888 → 0x8888, sat=1111; 0x4444+0xDDDD → 0x1111, sat=0000; 1-cycle latency.
- PSUBSB 0x7777−0x8888 → 0x7777, sat=1111; 0x1234−0x1111 → 0x0123, sat=0000. PADD 0x7777+0x1111 → 0x8888, sat=1111.
- RED A=0x1234 → out=0x000A after 4 cycles; A=0x8888 → 0xFFE0; A=0xFFFF → 0xFFFC; in_ready=0 during RED, in_valid pulses ignored.
- Back-pressure: out_ready=0 for 3 cycles after result → out/sat stable, in_ready=0; release with in_valid high and new PADDSB → new result next cycle, no bubble.
- Streaming: 8 consecutive PADDSB requests with out_ready=1 → 8 results on 8 consecutive cycles, in order, values matching reference model.
- rst asserted in 2nd RED cycle → next cycle IDLE, out=0, sat=0, out_valid=0, in_ready=1; subsequent RED 0x1111 → 0x0004.
